mux_scan_sampler: RTL and testbench

Round-robin scan controller for the 16-input multiplexer. It drives the multiplexer's 4-bit select and waits a programmable settle time. It then captures the multiplexer output and presents it downstream with its channel index over a valid/ready handshake. It sits between the 16:1 multiplexer (upstream data, downstream select) and the display/processing logic that consumes per-channel samples.

---
 rtl/mux_scan_pkg.sv | 9 +
 rtl/mux_scan_sampler_if.sv | 15 +
 rtl/mux_scan_sampler.sv | 70 +++++++
 tb/tb_mux_scan_sampler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared scan-state encoding and select width for the 16:1 mux family
package mux_scan_pkg;
    localparam int SEL_W = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;
endpackage

// File: rtl/mux_scan_sampler_if.sv
// mux_scan_sampler_if: mux select/sample bundle plus downstream valid/ready handshake
interface mux_scan_sampler_if #(parameter int WIDTH = 1);
    import mux_scan_pkg::*;
    logic             en;
    logic [WIDTH-1:0] mux_out;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] ch;
    logic             valid;
    logic             ready;
    logic             frame_done;
    logic             busy;
    modport master (input en, mux_out, ready, output sel, data, ch, valid, frame_done, busy);
    modport slave  (output en, mux_out, ready, input sel, data, ch, valid, frame_done, busy);
endinterface

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: round-robin mux select, settle wait, capture and valid/ready hand-off
module mux_scan_sampler #(
    parameter int WIDTH   = 1,
    parameter int SETTLE  = 2,
    parameter int LAST_CH = 15
) (
    input logic clk,
    input logic rst_n,
    mux_scan_sampler_if.master bus
);
    import mux_scan_pkg::SEL_W;
    import mux_scan_pkg::state_t;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_CH);
    localparam logic [SEL_W-1:0] CAP  = SEL_W'(SETTLE - 1);
    state_t           state;
    logic [SEL_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= mux_scan_pkg::IDLE;
            cnt            <= '0;
            bus.sel        <= '0;
            bus.data       <= '0;
            bus.ch         <= '0;
            bus.valid      <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                mux_scan_pkg::IDLE: begin
                    if (bus.en) begin
                        state    <= mux_scan_pkg::SETTLE;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                mux_scan_pkg::SETTLE: begin
                    // an abort wins over a capture due on the same edge
                    if (!bus.en) begin
                        state    <= mux_scan_pkg::IDLE;
                        bus.sel  <= '0;
                        bus.busy <= 1'b0;
                    end else if (cnt == CAP) begin
                        state     <= mux_scan_pkg::HOLD;
                        bus.data  <= bus.mux_out;
                        bus.ch    <= bus.sel;
                        bus.valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                mux_scan_pkg::HOLD: begin
                    if (bus.ready) begin
                        bus.valid      <= 1'b0;
                        bus.frame_done <= (bus.sel == LAST);
                        cnt            <= '0;
                        state          <= bus.en ? mux_scan_pkg::SETTLE : mux_scan_pkg::IDLE;
                        bus.busy       <= bus.en;
                        bus.sel        <= (!bus.en || bus.sel == LAST) ? '0 : bus.sel + 1'b1;
                    end
                end
                default: begin
                    state    <= mux_scan_pkg::IDLE;
                    bus.sel  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb_mux_scan_sampler: three parameterisations share one stimulus stream; each has a
// sample-level reference model feeding a scoreboard that a negedge monitor drains.
module tb_mux_scan_sampler;
    localparam int W = 8;

    typedef struct {
        logic [3:0]   ch;
        logic [W-1:0] data;
    } smp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic ready = 1'b1;
    int checks = 0;
    int errors = 0;

    function automatic void chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s got %0h expected %0h", inst, nm, act, exp);
        end
    endfunction

    genvar i;
    for (i = 0; i < 3; i++) begin : g
        localparam int S = (i == 1) ? 1 : 2;
        localparam int L = (i == 0) ? 15 : (i == 1) ? 3 : 0;

        mux_scan_sampler_if #(.WIDTH(W)) bus ();
        assign bus.en      = en;
        assign bus.ready   = ready;
        assign bus.mux_out = W'(8'hA0 + bus.sel);

        mux_scan_sampler #(.WIDTH(W), .SETTLE(S), .LAST_CH(L)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        // reference: which channel is next, whether a sample is owed/pending, when it is due
        smp_t q[$];
        int  t = 0, due = 0, nxt = 0;
        bit  scan = 0, pend = 0, fd = 0;
        initial forever begin
            @(posedge clk);
            t++;
            fd = 0;
            if (!rst_n) begin
                scan = 0; pend = 0; nxt = 0;
            end else if (pend) begin
                if (ready) begin
                    fd   = (nxt == L);
                    nxt  = (!en || nxt == L) ? 0 : nxt + 1;
                    pend = 0;
                    scan = en;
                    due  = t + S;
                end
            end else if (scan) begin
                if (!en) begin
                    scan = 0; nxt = 0;
                end else if (t == due) begin
                    pend = 1;
                    q.push_back('{ch: 4'(nxt), data: W'(8'hA0 + nxt)});
                end
            end else if (en) begin
                scan = 1;
                due  = t + S;
            end
        end

        smp_t cur = '{ch: '0, data: '0};
        bit   pv  = 0;
        initial forever begin
            @(negedge clk);
            chk(i, "valid", 32'(bus.valid), 32'(pend));
            chk(i, "busy", 32'(bus.busy), 32'(scan || pend));
            chk(i, "frame_done", 32'(bus.frame_done), 32'(fd));
            chk(i, "sel", 32'(bus.sel), 32'(nxt));
            if (bus.valid === 1'b1 && !pv) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL u%0d unexpected_sample got ch %0h expected none", i, bus.ch);
                end else cur = q.pop_front();
            end
            if (bus.valid === 1'b1) begin
                chk(i, "ch", 32'(bus.ch), 32'(cur.ch));
                chk(i, "data", 32'(bus.data), 32'(cur.data));
            end
            pv = (bus.valid === 1'b1);
        end
    end

    task automatic wait_for(input int s, input bit v);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (g[0].bus.sel == 4'(s) && g[0].bus.valid == v) return;
        end
        errors++;
        $display("FAIL u0 timeout got sel %0h valid %0b expected sel %0h valid %0b", g[0].bus.sel, g[0].bus.valid, s, v);
    endtask

    initial begin
        int nfd;
        repeat (3) @(negedge clk);
        chk(0, "rst_data", 32'(g[0].bus.data), 0);
        chk(0, "rst_ch", 32'(g[0].bus.ch), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        nfd   = 0;
        for (int k = 0; k < 55; k++) begin
            @(negedge clk);
            nfd += int'(g[0].bus.frame_done);
        end
        chk(0, "frame_done_count", 32'(nfd), 1);

        wait_for(5, 0);
        ready = 1'b0;
        wait_for(5, 1);
        repeat (10) @(negedge clk);
        chk(0, "stall_ch", 32'(g[0].bus.ch), 5);
        chk(0, "stall_data", 32'(g[0].bus.data), 32'hA5);
        chk(0, "stall_sel", 32'(g[0].bus.sel), 5);
        ready = 1'b1;
        @(negedge clk);
        chk(0, "after_stall_sel", 32'(g[0].bus.sel), 6);

        wait_for(3, 0);
        en = 1'b0;
        @(negedge clk);
        chk(0, "abort_busy", 32'(g[0].bus.busy), 0);
        chk(0, "abort_sel", 32'(g[0].bus.sel), 0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk(0, "restart_valid", 32'(g[0].bus.valid), 1);
        chk(0, "restart_ch", 32'(g[0].bus.ch), 0);

        wait_for(7, 0);
        ready = 1'b0;
        wait_for(7, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk(0, "stop_hold_ch", 32'(g[0].bus.ch), 7);
        ready = 1'b1;
        @(negedge clk);
        chk(0, "stop_busy", 32'(g[0].bus.busy), 0);
        chk(0, "stop_sel", 32'(g[0].bus.sel), 0);

        en = 1'b1;
        wait_for(9, 0);
        ready = 1'b0;
        wait_for(9, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk(0, "midrst_data", 32'(g[0].bus.data), 0);
        chk(0, "midrst_ch", 32'(g[0].bus.ch), 0);
        chk(0, "midrst_valid", 32'(g[0].bus.valid), 0);
        chk(0, "midrst_busy", 32'(g[0].bus.busy), 0);
        rst_n = 1'b1;
        ready = 1'b1;

        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            en    = $urandom_range(0, 9) != 0;
            ready = $urandom_range(0, 2) != 0;
            rst_n = $urandom_range(0, 199) != 0;
        end
        rst_n = 1'b1;
        en    = 1'b0;
        ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
